// File: rtl/uart_mem_bridge.sv
// ============================================================================
//  Module   : uart_mem_bridge
//  Purpose  : Turns host command bytes from the UART receiver into single-word
//             memory reads/writes and halt/run control over the mu0 memory
//             override port. Response bytes go back out to the transmitter.
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module uart_mem_bridge #(
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overrideMemControl,
  output logic        overrideMemRnW,
  output logic [15:0] overrideMemAddr,
  output logic [15:0] overrideMemDataIn,
  input  logic [15:0] overrideMemDataOut,
  output logic        halted,
  output logic        rx_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] c_lat_last = LW'(MEM_LATENCY - 1);

  localparam logic [7:0] c_op_write = 8'h57;
  localparam logic [7:0] c_op_read  = 8'h52;
  localparam logic [7:0] c_op_halt  = 8'h48;
  localparam logic [7:0] c_op_go    = 8'h47;
  localparam logic [7:0] c_rsp_ok   = 8'h4B;
  localparam logic [7:0] c_rsp_bad  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARGS   = 3'd1,
    S_MEM_WR = 3'd2,
    S_MEM_RD = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_is_write;   // command in ARGS is 'W' (4 args) rather than 'R' (2 args)
  logic [1:0]      r_arg_cnt;    // argument bytes already collected
  logic [23:0]     r_args;       // earlier argument bytes, oldest in the top
  logic [TW-1:0]   r_tmo;
  logic [LW-1:0]   r_lat;
  logic [7:0]      r_low_byte;   // second response byte of a read
  logic            r_more;       // a second response byte is still pending
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_rnw;
  logic [15:0]     r_addr;
  logic [15:0]     r_din;
  logic            r_halted;
  logic            r_overrun;

  // Full big-endian argument word including the byte arriving this cycle
  logic [31:0]     w_full;
  logic            w_last_arg;

  assign w_full     = {r_args, rx_data};
  assign w_last_arg = (r_arg_cnt == (r_is_write ? 2'd3 : 2'd1));

  assign tx_data            = r_tx_data;
  assign tx_valid           = r_tx_valid;
  assign overrideMemRnW     = r_rnw;
  assign overrideMemAddr    = r_addr;
  assign overrideMemDataIn  = r_din;
  assign halted             = r_halted;
  assign rx_overrun         = r_overrun;
  assign overrideMemControl = r_halted || (r_state == S_MEM_WR) || (r_state == S_MEM_RD);

  // Command FSM: parse, access memory, then stream the response bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_arg_cnt  <= 2'd0;
      r_args     <= 24'd0;
      r_tmo      <= '0;
      r_lat      <= '0;
      r_low_byte <= 8'h00;
      r_more     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_rnw      <= 1'b1;
      r_addr     <= 16'h0000;
      r_din      <= 16'h0000;
      r_halted   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (rx_valid) begin
            r_arg_cnt <= 2'd0;
            r_more    <= 1'b0;
            case (rx_data)
              c_op_write: begin
                r_is_write <= 1'b1;
                r_state    <= S_ARGS;
              end
              c_op_read: begin
                r_is_write <= 1'b0;
                r_state    <= S_ARGS;
              end
              c_op_halt: begin
                r_halted   <= 1'b1;
                r_tx_data  <= c_rsp_ok;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
              c_op_go: begin
                r_halted   <= 1'b0;
                r_tx_data  <= c_rsp_ok;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
              default: begin
                r_tx_data  <= c_rsp_bad;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
            endcase
          end
        end

        S_ARGS: begin
          if (rx_valid) begin
            r_tmo     <= '0;
            r_args    <= w_full[23:0];
            r_arg_cnt <= r_arg_cnt + 2'd1;
            if (w_last_arg) begin
              // Address/data are latched here so they are stable for the whole access
              if (r_is_write) begin
                r_addr  <= w_full[31:16];
                r_din   <= w_full[15:0];
                r_rnw   <= 1'b0;
                r_state <= S_MEM_WR;
              end else begin
                r_addr  <= w_full[15:0];
                r_rnw   <= 1'b1;
                r_lat   <= '0;
                r_state <= S_MEM_RD;
              end
            end
          end else if (r_tmo == c_tmo_last) begin
            // Host went quiet mid-command: drop it silently
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_MEM_WR: begin
          if (rx_valid) r_overrun <= 1'b1;
          r_rnw      <= 1'b1;
          r_tx_data  <= c_rsp_ok;
          r_tx_valid <= 1'b1;
          r_state    <= S_RESP;
        end

        S_MEM_RD: begin
          if (rx_valid) r_overrun <= 1'b1;
          if (r_lat == c_lat_last) begin
            r_tx_data  <= overrideMemDataOut[15:8];
            r_low_byte <= overrideMemDataOut[7:0];
            r_more     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end

        S_RESP: begin
          if (rx_valid) r_overrun <= 1'b1;
          if (r_tx_ready_hs(r_tx_valid, tx_ready)) begin
            if (r_more) begin
              r_tx_data <= r_low_byte;
              r_more    <= 1'b0;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Transmitter handshake qualifier
  function automatic logic r_tx_ready_hs(input logic v, input logic rdy);
    return v && rdy;
  endfunction

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
// ============================================================================
//  Module   : tb_uart_mem_bridge
//  Purpose  : Directed self-checking bench for uart_mem_bridge with a simple
//             combinational word memory behind the override port.
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module tb_uart_mem_bridge;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_ctl;
  logic        mem_rnw;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        halted;
  logic        rx_overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [0:65535];
  logic [7:0]  txq [$];
  int          wr_cnt = 0;
  int          rd_cycles = 0;
  logic [15:0] last_wa = 16'h0;
  logic [15:0] last_wd = 16'h0;

  uart_mem_bridge #(
    .MEM_LATENCY   (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .overrideMemControl(mem_ctl),
    .overrideMemRnW    (mem_rnw),
    .overrideMemAddr   (mem_addr),
    .overrideMemDataIn (mem_din),
    .overrideMemDataOut(mem_dout),
    .halted            (halted),
    .rx_overrun        (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency as seen by the bridge: data valid
  // during the cycle the address is presented, captured at its end.
  assign mem_dout = mem[mem_addr];

  // Memory write port
  always @(posedge clk) begin
    if (mem_ctl && !mem_rnw) mem[mem_addr] <= mem_din;
  end

  // Bus/transmit monitor sampled on the falling edge
  always @(negedge clk) begin
    if (mem_ctl && !mem_rnw) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_din;
    end
    if (mem_ctl && mem_rnw && !halted) rd_cycles <= rd_cycles + 1;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) until n response bytes have been collected
  task automatic wait_tx(input string tag, input int n);
    for (int i = 0; i < 300 && txq.size() < n; i++) @(posedge clk);
    check(tag, txq.size(), n);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (txq.size() > 0) ? txq.pop_front() : 8'hxx;
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_txv"},  tx_valid,   0);
    check({tag, "_txd"},  tx_data,    0);
    check({tag, "_ctl"},  mem_ctl,    0);
    check({tag, "_rnw"},  mem_rnw,    1);
    check({tag, "_addr"}, mem_addr,   0);
    check({tag, "_din"},  mem_din,    0);
    check({tag, "_hlt"},  halted,     0);
    check({tag, "_ovr"},  rx_overrun, 0);
  endtask

  initial begin
    int base_wr;
    int base_rd;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("rst0");

    // Reset in the middle of collecting 'W' arguments
    send_byte(8'h57);
    send_byte(8'h12);
    pulse_reset();
    check_reset_outputs("rst_mid");
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_tx("rd0_cnt", 2);
    expect_tx("rd0_hi", 8'h5A);
    expect_tx("rd0_lo", 8'h5A);
    check("rd0_cycles", rd_cycles, 1);
    check("rd0_nowr", wr_cnt, 0);

    // Write then read back
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h23); send_byte(8'hBE); send_byte(8'hEF);
    wait_tx("wr_cnt_tx", 1);
    expect_tx("wr_k", 8'h4B);
    check("wr_cycles", wr_cnt, 1);
    check("wr_addr", last_wa, 16'h0123);
    check("wr_data", last_wd, 16'hBEEF);
    @(negedge clk);
    check("wr_rnw_back", mem_rnw, 1);
    check("wr_ctl_off", mem_ctl, 0);
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    wait_tx("rd1_cnt", 2);
    expect_tx("rd1_hi", 8'hBE);
    expect_tx("rd1_lo", 8'hEF);
    check("rd1_cycles", rd_cycles, 2);

    // Halt / go
    send_byte(8'h48);
    wait_tx("h_cnt", 1);
    expect_tx("h_k", 8'h4B);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("h_halted", halted, 1);
    check("h_ctl", mem_ctl, 1);
    send_byte(8'h47);
    wait_tx("g_cnt", 1);
    expect_tx("g_k", 8'h4B);
    @(negedge clk);
    check("g_halted", halted, 0);
    check("g_ctl", mem_ctl, 0);

    // Unknown opcode
    base_wr = wr_cnt;
    base_rd = rd_cycles;
    send_byte(8'h55);
    wait_tx("unk_cnt", 1);
    expect_tx("unk_q", 8'h3F);
    check("unk_nowr", wr_cnt, base_wr);
    check("unk_nord", rd_cycles, base_rd);

    // Timeout mid-command, then 'H' must be taken as an opcode
    send_byte(8'h52); send_byte(8'h00);
    repeat (25) @(posedge clk);
    check("tmo_notx", txq.size(), 0);
    check("tmo_nord", rd_cycles, base_rd);
    send_byte(8'h48);
    wait_tx("tmo_h_cnt", 1);
    expect_tx("tmo_h_k", 8'h4B);
    @(negedge clk);
    check("tmo_halted", halted, 1);
    check("tmo_nord2", rd_cycles, base_rd);
    send_byte(8'h47);
    wait_tx("tmo_g_cnt", 1);
    expect_tx("tmo_g_k", 8'h4B);

    // All-ones address and data
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    wait_tx("ff_wcnt", 1);
    expect_tx("ff_k", 8'h4B);
    check("ff_addr", last_wa, 16'hFFFF);
    check("ff_data", last_wd, 16'hFFFF);
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
    wait_tx("ff_rcnt", 2);
    expect_tx("ff_hi", 8'hFF);
    expect_tx("ff_lo", 8'hFF);

    // Transmitter stall during a read response, with a byte arriving meanwhile
    @(negedge clk);
    check("ovr_before", rx_overrun, 0);
    @(posedge clk); #1 tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    check("stall_txv", tx_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", tx_data, 8'hBE);
      if (i == 3) send_byte(8'h47);
    end
    check("stall_ovr", rx_overrun, 1);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx("stall_cnt", 2);
    expect_tx("stall_hi", 8'hBE);
    expect_tx("stall_lo", 8'hEF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_txv_off", tx_valid, 0);
    check("ovr_sticky", rx_overrun, 1);
    check("ovr_g_dropped", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
